// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a stalling data-memory handshake, load/store lane formatting and a registered MEM/WB result.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned lw/sw/lh/lhu/sh accesses instead of issuing them.
module mem_stage #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_load_regfile,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_byte_enable,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        mem_stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_load_regfile,
   output logic [31:0] wb_data,
   output logic        timeout_err,
   output logic        misalign
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [4:0]  rd_q;
   logic        lrf_q;
   logic        load_q;
   logic [1:0]  off;
   logic        memop;
   logic        mis;
   logic        accept;
   logic        tmo;
   logic [3:0]  be_base;
   logic [7:0]  lb_byte;
   logic [15:0] lh_half;
   logic [31:0] ld_fmt;

   assign off = ex_alu_out[1:0];
   assign memop = ex_valid & (ex_mem_read | ex_mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = memop & (state != REQ) & (((ex_funct3[1:0] == 2'b10) & (off != 2'b00)) | ((ex_funct3[1:0] == 2'b01) & off[0]));
`else
   assign mis = 1'b0;
`endif
   assign accept = memop & (state != REQ) & ~mis;
   assign mem_stall = accept | (state == REQ);
   assign tmo = (cnt == 16'(MAX_WAIT - 1));
   assign be_base = (ex_funct3[1:0] == 2'b00) ? 4'b0001 : (ex_funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
   assign lb_byte = dmem_rdata[{off_q, 3'b000} +: 8];
   assign lh_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   assign ld_fmt = (f3_q == 3'b000) ? {{24{lb_byte[7]}}, lb_byte} :
                   (f3_q == 3'b100) ? {24'd0, lb_byte} :
                   (f3_q == 3'b001) ? {{16{lh_half[15]}}, lh_half} :
                   (f3_q == 3'b101) ? {16'd0, lh_half} : dmem_rdata;

   // FSM: issue/hold the memory request, wait for response or timeout, and register the write-back result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         cnt              <= 16'd0;
         f3_q             <= 3'd0;
         off_q            <= 2'd0;
         rd_q             <= 5'd0;
         lrf_q            <= 1'b0;
         load_q           <= 1'b0;
         dmem_read        <= 1'b0;
         dmem_write       <= 1'b0;
         dmem_address     <= 32'd0;
         dmem_wdata       <= 32'd0;
         dmem_byte_enable <= 4'd0;
         wb_valid         <= 1'b0;
         wb_rd            <= 5'd0;
         wb_load_regfile  <= 1'b0;
         wb_data          <= 32'd0;
         timeout_err      <= 1'b0;
         misalign         <= 1'b0;
      end else if (state == REQ) begin
         misalign <= 1'b0;
         cnt      <= cnt + 16'd1;
         if (dmem_resp | tmo) begin
            state            <= DONE;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= 4'd0;
            wb_valid         <= 1'b1;
            wb_rd            <= rd_q;
            wb_load_regfile  <= lrf_q;
            wb_data          <= (dmem_resp & load_q) ? ld_fmt : 32'd0;
            timeout_err      <= timeout_err | ~dmem_resp;
         end
      end else begin
         state           <= accept ? REQ : IDLE;
         cnt             <= 16'd0;
         wb_valid        <= ex_valid & ~accept;
         wb_rd           <= ex_rd;
         wb_load_regfile <= ex_valid & ~memop & ex_load_regfile;
         wb_data         <= memop ? 32'd0 : ex_alu_out;
         misalign        <= mis;
         if (accept) begin
            dmem_read        <= ex_mem_read;
            dmem_write       <= ex_mem_write & ~ex_mem_read;
            dmem_address     <= {ex_alu_out[31:2], 2'b00};
            dmem_wdata       <= ex_mem_read ? 32'd0 : ex_rs2 << {off, 3'b000};
            dmem_byte_enable <= ex_mem_read ? 4'd0 : be_base << off;
            f3_q             <= ex_funct3;
            off_q            <= off;
            rd_q             <= ex_rd;
            lrf_q            <= ex_load_regfile;
            load_q           <= ex_mem_read;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_load_regfile = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [31:0] ex_alu_out = 32'd0, ex_rs2 = 32'd0, dmem_rdata = 32'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic        dmem_resp = 1'b0;
   logic        dmem_read, dmem_write, mem_stall, wb_valid, wb_load_regfile, timeout_err, misalign;
   logic [31:0] dmem_address, dmem_wdata, wb_data;
   logic [3:0]  dmem_byte_enable;
   logic [4:0]  wb_rd;

   typedef struct {
      logic [4:0]  rd;
      logic        lrf;
      logic [31:0] data;
      logic        mis;
      logic        chk_data;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad = 0;

   mem_stage #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_load_regfile(ex_load_regfile), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .mem_stall(mem_stall), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile), .wb_data(wb_data),
      .timeout_err(timeout_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // monitor: every write-back the DUT presents is matched against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got wb_valid=1 data %h want no write-back", wb_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_lrf", 32'(wb_load_regfile), 32'(e.lrf));
            check("wb_misalign", 32'(misalign), 32'(e.mis));
            if (e.chk_data) check("wb_data", wb_data, e.data);
         end
      end
   end

   task automatic mem_op(input string nm, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdn, input logic lrf,
                         input int n, input logic [31:0] rdata, input logic resp, input logic [31:0] exp_data,
                         input logic exp_wr, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
      int stalls = 0;
      q.push_back('{rdn, lrf, exp_data, 1'b0, r});
      ex_valid = 1'b1; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
      ex_alu_out = a; ex_rs2 = d; ex_rd = rdn; ex_load_regfile = lrf;
      @(negedge clk);
      if (mem_stall) stalls++;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         dmem_resp = resp && (i == n);
         dmem_rdata = rdata;
         @(negedge clk);
         if (mem_stall) stalls++;
         check({nm, "_dread"}, 32'(dmem_read), 32'(r));
         check({nm, "_dwrite"}, 32'(dmem_write), 32'(exp_wr));
         check({nm, "_addr"}, dmem_address, {a[31:2], 2'b00});
         if (exp_wr) begin
            check({nm, "_wdata"}, dmem_wdata, exp_wdata);
            check({nm, "_be"}, 32'(dmem_byte_enable), 32'(exp_be));
         end
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      @(negedge clk);
      check({nm, "_stalls"}, 32'(stalls), 32'(n + 1));
      check({nm, "_done_stall"}, 32'(mem_stall), 32'd0);
      check({nm, "_dropped"}, 32'({dmem_read, dmem_write}), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic alu(input logic [31:0] v, input logic [4:0] rdn, input logic lrf, input logic prev_wb);
      q.push_back('{rdn, lrf, v, 1'b0, 1'b1});
      ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_alu_out = v; ex_rd = rdn; ex_load_regfile = lrf;
      @(negedge clk);
      check("alu_stall", 32'(mem_stall), 32'd0);
      check("alu_wb_prev", 32'(wb_valid), 32'(prev_wb));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_wbv", 32'(wb_valid), 32'd0);
      check("rst_dmem", 32'({dmem_read, dmem_write, dmem_byte_enable}), 32'd0);
      check("rst_err", 32'({timeout_err, misalign}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_op("lw",  1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 0);
      mem_op("lb",  1, 0, 3'b000, 32'h103, 0, 5'd6, 1, 1, 32'h80FF0000, 1, 32'hFFFFFF80, 0, 0, 0);
      mem_op("lbu", 1, 0, 3'b100, 32'h103, 0, 5'd7, 1, 1, 32'h80FF0000, 1, 32'h00000080, 0, 0, 0);
      mem_op("lh",  1, 0, 3'b001, 32'h102, 0, 5'd8, 1, 2, 32'h80FF0000, 1, 32'hFFFF80FF, 0, 0, 0);
      mem_op("lhu", 1, 0, 3'b101, 32'h102, 0, 5'd9, 1, 1, 32'h80FF0000, 1, 32'h000080FF, 0, 0, 0);
      mem_op("sh",  0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 0, 3, 0, 1, 0, 1, 32'hABCD0000, 4'b1100);
      mem_op("sb",  0, 1, 3'b000, 32'h101, 32'h000000AA, 5'd0, 0, 1, 0, 1, 0, 1, 32'h0000AA00, 4'b0010);
      mem_op("sw",  0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 5'd0, 0, 2, 0, 1, 0, 1, 32'hCAFEF00D, 4'b1111);
      mem_op("rw",  1, 1, 3'b010, 32'h108, 32'h99999999, 5'd10, 1, 1, 32'h11223344, 1, 32'h11223344, 0, 0, 0);
      alu(32'h55, 5'd3, 1'b1, 1'b0);
      alu(32'h66, 5'd4, 1'b1, 1'b1);
      alu(32'h77, 5'd5, 1'b0, 1'b1);
      ex_valid = 1'b0;
      @(negedge clk);
      check("alu_last_wbv", 32'(wb_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bubble_wbv", 32'({wb_valid, wb_load_regfile}), 32'd0);
      @(posedge clk); #1;
      dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      check("stray_resp_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      @(negedge clk);
      check("stray_resp_wbv", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      check("pre_tmo_err", 32'(timeout_err), 32'd0);
      mem_op("tmo", 1, 0, 3'b010, 32'h200, 0, 5'd11, 1, 4, 32'hFFFFFFFF, 0, 32'd0, 0, 0, 0);
      check("tmo_err", 32'(timeout_err), 32'd1);
      alu(32'h1234, 5'd12, 1'b1, 1'b0);
      ex_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("tmo_sticky", 32'(timeout_err), 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
      q.push_back('{5'd13, 1'b0, 32'd0, 1'b1, 1'b0});
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h101; ex_rd = 5'd13; ex_load_regfile = 1'b1;
      @(negedge clk);
      check("mis_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_read = 1'b0;
      @(negedge clk);
      check("mis_noreq", 32'(dmem_read), 32'd0);
      check("mis_pulse", 32'(misalign), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_clear", 32'(misalign), 32'd0);
      @(posedge clk); #1;
`endif
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h300; ex_rd = 5'd14; ex_load_regfile = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstreq_read", 32'(dmem_read), 32'd1);
      #2;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0;
      #1;
      check("rstreq_drop", 32'(dmem_read), 32'd0);
      check("rstreq_stall", 32'(mem_stall), 32'd0);
      check("rstreq_err", 32'(timeout_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstreq_wbv", 32'(wb_valid), 32'd0);
      @(negedge clk);
      check("rstreq_idle", 32'({wb_valid, dmem_read, mem_stall}), 32'd0);
      check("sb_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
